divider_iter: RTL and testbench
===============================

DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 Parameters: none; widths use `XLEN (32) from the shared defines.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 exe2div_i  in  type_exe2div_s  alu_operand_1 (dividend), alu_operand_2 (divisor), alu_d_ops (operation), driven by the execute stage.
REQ-005 div_flush_i  in  1  pipeline kill; abandons any in-flight division.
REQ-006 div_result_o  out  XLEN  quotient or remainder; meaningful only while div_valid_o=1.
REQ-007 div_valid_o  out  1  one-cycle pulse marking the result cycle.
REQ-008 div_stall_o  out  1  stall request to the pipeline; while high, the execute stage holds exe2div_i stable.

Function
REQ-009 alu_d_ops encodings: NONE=0, DIV, DIVU, REM, REMU; any non-NONE value is a request.
REQ-010 FSM states: IDLE, CALC, DONE.
REQ-011 IDLE: request present and div_flush_i=0 -> latch operands and op; div_stall_o=1 combinationally in the same cycle.
- Divisor zero or signed overflow -> go to DONE.
- Otherwise -> go to CALC with iteration counter=0.
REQ-012 CALC: restoring radix-2 on operand magnitudes, one quotient bit per cycle, MSB first.
- Exactly XLEN cycles; counter 6 bits, 0..31.
- Counter=31 -> go to DONE.
- div_stall_o=1 throughout.
REQ-013 DONE: div_valid_o=1, div_stall_o=0, div_result_o valid; unconditional return to IDLE next cycle.
- The request still present on exe2div_i in DONE is the completed instruction and SHALL NOT start a new division.
REQ-014 Latency: normal request accepted at cycle T -> stall high T..T+32, valid at T+33; special cases (REQ-017, REQ-018) -> stall high at T, valid at T+1.
REQ-015 Signed ops (DIV/REM): divide magnitudes.
- Quotient negated when operand signs differ.
- Remainder takes the dividend's sign.
REQ-016 Unsigned ops (DIVU/REMU): operands used as is.
REQ-017 Divisor zero:
- DIV/DIVU quotient = all ones.
- REM/REMU remainder = dividend.
REQ-018 DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-019 div_flush_i=1 in any state -> IDLE next cycle; no div_valid_o pulse; div_stall_o=0 in that cycle.
- Flush has priority over a request arriving in the same cycle.
REQ-020 div_result_o SHALL be 0 whenever div_valid_o=0.

Reset
REQ-021 rst_n low -> immediately:
- FSM in IDLE.
- Counter, operand, quotient and remainder registers cleared.
- div_valid_o=0, div_stall_o=0, div_result_o=0.
REQ-022 Reset mid-CALC SHALL discard the operation with no valid pulse after release.
- The first request after release SHALL be accepted normally.

Structure
REQ-023 The shared package SHALL hold:
- type_alu_d_ops_e and type_exe2div_s (shared with the execute stage);
- the FSM state enum type_div_state_e;
- the iteration-count constant DIV_ITER = XLEN.
REQ-024 One sub-module is natural: div_sign_fix, the combinational magnitude/negation logic for operands and results.
- The FSM and iteration datapath stay in divider_iter.

Verification
REQ-025 DIVU 100/7 -> valid at T+33, result 14; REMU 100/7 -> 2; stall high for exactly 33 cycles.
REQ-026 DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2); DIV 20/-3 -> -6.
REQ-027 Zero divisor:
- DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
- Both valid at T+1.
REQ-028 Signed overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both valid at T+1.
REQ-029 Flush mid-operation:
- div_flush_i pulsed at CALC iteration 10 -> no valid pulse, stall low, IDLE.
- Next DIVU 9/3 -> 3 at acceptance+33.
REQ-030 Reset and back-to-back requests:
- rst_n asserted mid-CALC -> all outputs 0 immediately.
- Back-to-back requests -> each produces exactly one valid pulse, with no spurious restart in DONE.

Source files
------------

// File: rtl/divider_iter_pkg.sv
// ============================================================================
// divider_iter_pkg : shared types and constants for the iterative divider
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package divider_iter_pkg;

    localparam int XLEN     = `XLEN;
    localparam int DIV_ITER = XLEN;
    localparam int CNT_W    = 6;

    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        ALU_D_NONE = 3'd0,
        ALU_D_DIV  = 3'd1,
        ALU_D_DIVU = 3'd2,
        ALU_D_REM  = 3'd3,
        ALU_D_REMU = 3'd4
    } type_alu_d_ops_e;

    typedef struct packed {
        logic [XLEN-1:0] alu_operand_1;
        logic [XLEN-1:0] alu_operand_2;
        type_alu_d_ops_e alu_d_ops;
    } type_exe2div_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } type_div_state_e;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/divider_iter_if.sv
// ============================================================================
// divider_iter_if : execute-stage <-> divider handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface divider_iter_if;
    import divider_iter_pkg::*;

    type_exe2div_s   exe2div_i;
    logic            div_flush_i;
    logic [XLEN-1:0] div_result_o;
    logic            div_valid_o;
    logic            div_stall_o;

    modport master (
        output exe2div_i, div_flush_i,
        input  div_result_o, div_valid_o, div_stall_o
    );

    modport slave (
        input  exe2div_i, div_flush_i,
        output div_result_o, div_valid_o, div_stall_o
    );

endinterface

`default_nettype wire

// File: rtl/divider_iter_sign_fix.sv
// ============================================================================
// div_sign_fix : operand magnitudes, special-case detection, result signing
// Rev 1.0
// ============================================================================
`default_nettype none

module div_sign_fix
    import divider_iter_pkg::*;
(
    input  type_alu_d_ops_e op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [XLEN-1:0] quo_mag_i,
    input  logic [XLEN-1:0] rem_mag_i,
    output logic [XLEN-1:0] dividend_mag_o,
    output logic [XLEN-1:0] divisor_mag_o,
    output logic [XLEN-1:0] result_o,
    output logic            special_o
);

    logic w_signed_op, w_rem_op, w_dvd_neg, w_dvs_neg, w_div_zero, w_ovf;

    assign w_signed_op = (op_i == ALU_D_DIV) || (op_i == ALU_D_REM);
    assign w_rem_op    = (op_i == ALU_D_REM) || (op_i == ALU_D_REMU);
    assign w_dvd_neg   = w_signed_op & dividend_i[XLEN-1];
    assign w_dvs_neg   = w_signed_op & divisor_i[XLEN-1];
    assign w_div_zero  = (divisor_i == '0);
    assign w_ovf       = w_signed_op && (dividend_i == XLEN_MIN) && (divisor_i == '1);

    assign dividend_mag_o = w_dvd_neg ? twos_neg(dividend_i) : dividend_i;
    assign divisor_mag_o  = w_dvs_neg ? twos_neg(divisor_i)  : divisor_i;
    assign special_o      = w_div_zero | w_ovf;

    always_comb begin
        result_o = '0;
        if (w_div_zero) begin
            result_o = w_rem_op ? dividend_i : '1;
        end else if (w_ovf) begin
            result_o = w_rem_op ? '0 : XLEN_MIN;
        end else if (w_rem_op) begin
            // remainder follows the dividend's sign
            result_o = w_dvd_neg ? twos_neg(rem_mag_i) : rem_mag_i;
        end else begin
            result_o = (w_dvd_neg ^ w_dvs_neg) ? twos_neg(quo_mag_i) : quo_mag_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/divider_iter.sv
// ============================================================================
// divider_iter : restoring radix-2 divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module divider_iter
    import divider_iter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    divider_iter_if.slave div_if
);

    type_div_state_e state_q, state_d;
    type_alu_d_ops_e op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
    logic [XLEN-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, result_q, result_d;
    logic             valid_q, valid_d, stall;

    logic            req, special, step_ge;
    type_alu_d_ops_e src_op;
    logic [XLEN-1:0] src_dvd, src_dvs, dvd_mag, dvs_mag, fix_result;
    logic [XLEN-1:0] rem_sub, rem_step, quo_step;
    logic [XLEN:0]   rem_shift;

    assign req = (div_if.exe2div_i.alu_d_ops != ALU_D_NONE);

    // live operands feed the sign logic at acceptance, latched ones afterwards
    assign src_op  = (state_q == ST_IDLE) ? div_if.exe2div_i.alu_d_ops     : op_q;
    assign src_dvd = (state_q == ST_IDLE) ? div_if.exe2div_i.alu_operand_1 : dvd_q;
    assign src_dvs = (state_q == ST_IDLE) ? div_if.exe2div_i.alu_operand_2 : dvs_q;

    div_sign_fix u_sign_fix (
        .op_i           (src_op),
        .dividend_i     (src_dvd),
        .divisor_i      (src_dvs),
        .quo_mag_i      (quo_step),
        .rem_mag_i      (rem_step),
        .dividend_mag_o (dvd_mag),
        .divisor_mag_o  (dvs_mag),
        .result_o       (fix_result),
        .special_o      (special)
    );

    // quo_q starts as the dividend magnitude and shifts its bits into the remainder
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign step_ge   = (rem_shift >= {1'b0, dsr_q});
    assign rem_sub   = rem_shift[XLEN-1:0] - dsr_q;
    assign rem_step  = step_ge ? rem_sub : rem_shift[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], step_ge};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        valid_d  = 1'b0;
        result_d = '0;
        stall    = 1'b0;

        if (div_if.div_flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        stall = 1'b1;
                        op_d  = div_if.exe2div_i.alu_d_ops;
                        dvd_d = div_if.exe2div_i.alu_operand_1;
                        dvs_d = div_if.exe2div_i.alu_operand_2;
                        if (special) begin
                            state_d  = ST_DONE;
                            valid_d  = 1'b1;
                            result_d = fix_result;
                        end else begin
                            state_d = ST_CALC;
                            cnt_d   = '0;
                            quo_d   = dvd_mag;
                            rem_d   = '0;
                            dsr_d   = dvs_mag;
                        end
                    end
                end
                ST_CALC: begin
                    stall = 1'b1;
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b1;
                        result_d = fix_result;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_D_NONE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign div_if.div_stall_o  = rst_n & stall;
    assign div_if.div_valid_o  = valid_q & ~div_if.div_flush_i;
    assign div_if.div_result_o = div_if.div_flush_i ? '0 : result_q;

endmodule

`default_nettype wire

// File: tb/tb_divider_iter.sv
// ============================================================================
// tb_divider_iter : randomized self-checking bench for divider_iter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_divider_iter;
    import divider_iter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    divider_iter_if dif ();

    divider_iter u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: plain 64-bit arithmetic, special cases straight from the rules
    function automatic logic [31:0] ref_div(input type_alu_d_ops_e op,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        bit     sgn, rem;
        sgn = (op == ALU_D_DIV) || (op == ALU_D_REM);
        rem = (op == ALU_D_REM) || (op == ALU_D_REMU);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return rem ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input type_alu_d_ops_e op,
                                   input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (op == ALU_D_DIV) || (op == ALU_D_REM);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic drive_req(input type_alu_d_ops_e op, input logic [31:0] a, input logic [31:0] b);
        dif.exe2div_i.alu_operand_1 = a;
        dif.exe2div_i.alu_operand_2 = b;
        dif.exe2div_i.alu_d_ops     = op;
    endtask

    // called just after a falling edge; request is held through the DONE cycle
    task automatic run_op(input string tag, input type_alu_d_ops_e op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        int lat, stall_cnt, dirty, exp_lat;
        bit got;
        exp_lat = ref_lat(op, a, b);
        drive_req(op, a, b);
        #1;
        stall_cnt = dif.div_stall_o ? 1 : 0;
        lat = 0; got = 0; dirty = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (dif.div_valid_o) got = 1'b1;
            else begin
                if (dif.div_stall_o) stall_cnt++;
                if (dif.div_result_o !== 32'd0) dirty++;
            end
        end
        chk({tag, " valid seen"}, 32'(got), 32'd1);
        chk({tag, " result"}, dif.div_result_o, exp_res);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " stall cycles"}, stall_cnt, exp_lat);
        chk({tag, " stall in done"}, 32'(dif.div_stall_o), 32'd0);
        chk({tag, " result zero while not valid"}, dirty, 32'd0);
        @(negedge clk);
        drive_req(ALU_D_NONE, 32'd0, 32'd0);
        #1;
        chk({tag, " single pulse"}, 32'(dif.div_valid_o), 32'd0);
        chk({tag, " no restart from done"}, 32'(dif.div_stall_o), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int pulses, stalls;
        pulses = 0; stalls = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dif.div_valid_o) pulses++;
            if (dif.div_stall_o) stalls++;
        end
        chk({tag, " no valid"}, pulses, 32'd0);
        chk({tag, " no stall"}, stalls, 32'd0);
    endtask

    initial begin
        type_alu_d_ops_e op;
        logic [31:0] a, b;
        int sel;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        dif.div_flush_i = 1'b0;
        drive_req(ALU_D_DIVU, 32'd100, 32'd7);

        @(negedge clk);
        #1;
        chk("reset valid", 32'(dif.div_valid_o), 32'd0);
        chk("reset stall", 32'(dif.div_stall_o), 32'd0);
        chk("reset result", dif.div_result_o, 32'd0);
        drive_req(ALU_D_NONE, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu 100/7", ALU_D_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu 100/7", ALU_D_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div -20/3", ALU_D_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_op("rem -20/3", ALU_D_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run_op("div 20/-3", ALU_D_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
        run_op("divu x/0", ALU_D_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run_op("rem x/0", ALU_D_REM, 32'h1234, 32'd0, 32'h1234);
        run_op("div ovf", ALU_D_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", ALU_D_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // flush at CALC iteration 10
        drive_req(ALU_D_DIVU, 32'hFFFF_0000, 32'd3);
        repeat (11) @(negedge clk);
        dif.div_flush_i = 1'b1;
        #1;
        chk("flush stall", 32'(dif.div_stall_o), 32'd0);
        chk("flush valid", 32'(dif.div_valid_o), 32'd0);
        @(negedge clk);
        dif.div_flush_i = 1'b0;
        drive_req(ALU_D_NONE, 32'd0, 32'd0);
        expect_quiet("after flush", 40);

        // flush beats a request arriving in the same cycle
        drive_req(ALU_D_DIVU, 32'd9, 32'd3);
        dif.div_flush_i = 1'b1;
        #1;
        chk("flush prio stall", 32'(dif.div_stall_o), 32'd0);
        @(negedge clk);
        dif.div_flush_i = 1'b0;
        drive_req(ALU_D_NONE, 32'd0, 32'd0);
        expect_quiet("flush prio", 36);
        run_op("divu 9/3 post flush", ALU_D_DIVU, 32'd9, 32'd3, 32'd3);

        // asynchronous reset mid-CALC
        drive_req(ALU_D_DIVU, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset valid", 32'(dif.div_valid_o), 32'd0);
        chk("mid reset stall", 32'(dif.div_stall_o), 32'd0);
        chk("mid reset result", dif.div_result_o, 32'd0);
        drive_req(ALU_D_NONE, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("after reset", 40);
        run_op("remu post reset", ALU_D_REMU, 32'd100, 32'd7, 32'd2);

        // randomized back-to-back requests
        for (int i = 0; i < 40; i++) begin
            op  = type_alu_d_ops_e'(3'($urandom_range(4, 1)));
            sel = $urandom_range(7, 0);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(1000, 0)); b = 32'($urandom_range(20, 1)); end
                3: b = 32'($urandom_range(15, 1)) | ($urandom_range(1, 0) != 0 ? 32'hFFFF_FFF0 : 32'd0);
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b, ref_div(op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
